// File: rtl/lsu_pkg.sv
// Shared types and encodings for the load/store unit: FSM states, funct3 values,
// memory READ_WRITE_EN codes and response fault codes.
package lsu_pkg;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE   = 2'b00;
  localparam lsu_state_t ST_ACCESS = 2'b01;
  localparam lsu_state_t ST_RESP   = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] RWEN_NONE = 4'b0000;
  localparam logic [3:0] RWEN_LB   = 4'b1000;
  localparam logic [3:0] RWEN_LH   = 4'b1001;
  localparam logic [3:0] RWEN_LW   = 4'b1010;
  localparam logic [3:0] RWEN_LBU  = 4'b1100;
  localparam logic [3:0] RWEN_LHU  = 4'b1101;
  localparam logic [3:0] RWEN_SB   = 4'b1011;
  localparam logic [3:0] RWEN_SH   = 4'b1110;
  localparam logic [3:0] RWEN_SW   = 4'b1111;

  localparam logic [1:0] FAULT_NONE     = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;
  localparam logic [1:0] FAULT_ILLEGAL  = 2'b11;

endpackage

// File: rtl/lsu_decode.sv
// Combinational request decode: memory RWEN code, access size in bytes, and
// fault code with priority illegal > misaligned > out-of-range.
module lsu_decode
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  output logic [3:0]  rwen,
  output logic [2:0]  size,
  output logic [1:0]  fault
);

  localparam logic [32:0] LAST_VALID = 33'(MEM_BYTES) - 33'd1;

  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [32:0] last_byte;

  always_comb begin
    rwen    = RWEN_NONE;
    size    = 3'd1;
    illegal = 1'b0;
    case (funct3)
      F3_B: begin
        size = 3'd1;
        rwen = write ? RWEN_SB : RWEN_LB;
      end
      F3_H: begin
        size = 3'd2;
        rwen = write ? RWEN_SH : RWEN_LH;
      end
      F3_W: begin
        size = 3'd4;
        rwen = write ? RWEN_SW : RWEN_LW;
      end
      F3_BU: begin
        size    = 3'd1;
        illegal = write;
        rwen    = write ? RWEN_NONE : RWEN_LBU;
      end
      F3_HU: begin
        size    = 3'd2;
        illegal = write;
        rwen    = write ? RWEN_NONE : RWEN_LHU;
      end
      default: illegal = 1'b1;
    endcase
  end

  // 33-bit sum so an access near 4 GiB cannot wrap back into range
  assign last_byte    = {1'b0, addr} + {30'd0, size} - 33'd1;
  assign out_of_range = last_byte > LAST_VALID;
  assign misaligned   = ((size == 3'd2) && addr[0]) ||
                        ((size == 3'd4) && (addr[1:0] != 2'b00));

  always_comb begin
    if (illegal)           fault = FAULT_ILLEGAL;
    else if (misaligned)   fault = FAULT_MISALIGN;
    else if (out_of_range) fault = FAULT_RANGE;
    else                   fault = FAULT_NONE;
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between the pipeline and the data memory.
//   state  | meaning
//   IDLE   | ready for a request
//   ACCESS | one-cycle memory access, RWEN driven
//   RESP   | response held until RSP_READY
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 524288
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        REQ_VALID,
  output logic        REQ_READY,
  input  logic        REQ_WRITE,
  input  logic [2:0]  REQ_FUNCT3,
  input  logic [31:0] REQ_ADDR,
  input  logic [31:0] REQ_WDATA,
  output logic        RSP_VALID,
  input  logic        RSP_READY,
  output logic [31:0] RSP_RDATA,
  output logic [1:0]  RSP_FAULT,
  output logic [3:0]  MEM_RWEN,
  output logic [31:0] MEM_ADDR,
  output logic [31:0] MEM_WDATA,
  input  logic [31:0] MEM_RDATA
);

  lsu_state_t state;
  logic       write_q;
  logic [3:0] rwen_q;
  logic [3:0] dec_rwen;
  logic [2:0] dec_size;
  logic [1:0] dec_fault;

  lsu_decode #(.MEM_BYTES(MEM_BYTES)) u_decode (
    .write  (REQ_WRITE),
    .funct3 (REQ_FUNCT3),
    .addr   (REQ_ADDR),
    .rwen   (dec_rwen),
    .size   (dec_size),
    .fault  (dec_fault)
  );

  assign REQ_READY = (state == ST_IDLE);
  assign RSP_VALID = (state == ST_RESP);
  // Decoded from state so a reset mid-access removes the write strobe at once
  assign MEM_RWEN  = (state == ST_ACCESS) ? rwen_q : RWEN_NONE;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state     <= ST_IDLE;
      write_q   <= 1'b0;
      rwen_q    <= RWEN_NONE;
      MEM_ADDR  <= 32'd0;
      MEM_WDATA <= 32'd0;
      RSP_RDATA <= 32'd0;
      RSP_FAULT <= FAULT_NONE;
    end else begin
      case (state)
        ST_IDLE: begin
          if (REQ_VALID) begin
            write_q   <= REQ_WRITE;
            rwen_q    <= dec_rwen;
            MEM_ADDR  <= REQ_ADDR;
            MEM_WDATA <= REQ_WDATA;
            RSP_RDATA <= 32'd0;
            RSP_FAULT <= dec_fault;
            state     <= (dec_fault == FAULT_NONE) ? ST_ACCESS : ST_RESP;
          end
        end
        ST_ACCESS: begin
          RSP_RDATA <= write_q ? 32'd0 : MEM_RDATA;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (RSP_READY) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  logic unused_size;
  assign unused_size = ^dec_size;

endmodule
